// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-stage load/store responder with fixed wait states
module data_mem_responder #(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] ALU_result,
   input  logic [31:0] Val_Rm,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        freeze,
   output logic        addr_err
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic          oor_q, oor_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem_q [DEPTH];

   logic          req;
   logic [31:0]   offset;
   logic [31:0]   idx_full;
   logic          oor_now;
   logic          last;
   logic          commit_wr;

   assign req      = MEM_R_EN | MEM_W_EN;
   assign offset   = ALU_result - 32'(BASE_ADDR);
   assign idx_full = offset >> 2;
   assign oor_now  = (ALU_result < 32'(BASE_ADDR)) || (idx_full >= 32'(DEPTH));
   assign last     = (cnt_q == CW'(WAIT_CYCLES - 1));

   assign ready     = (state_q == DONE);
   assign freeze    = req & ~ready;
   assign read_data = rdata_q;
   assign addr_err  = err_q;

   // Store commits on the final busy edge; reset on that same edge aborts it.
   assign commit_wr = !rst && (state_q == BUSY) && last && wr_q && !oor_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      oor_d   = oor_q;
      idx_d   = idx_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = MEM_W_EN;
               oor_d   = oor_now;
               idx_d   = idx_full[IW-1:0];
               data_d  = Val_Rm;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               if (!wr_q) begin
                  rdata_d = oor_q ? 32'd0 : mem_q[idx_q];
               end
               err_d   = oor_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         oor_q   <= oor_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         mem_q[idx_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_result;
   logic [31:0] Val_Rm;
   logic [31:0] read_data;
   logic        ready;
   logic        freeze;
   logic        addr_err;

   int          n_vec;
   int          n_err;
   logic [31:0] model [64];

   data_mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .ALU_result (ALU_result),
      .Val_Rm     (Val_Rm),
      .read_data  (read_data),
      .ready      (ready),
      .freeze     (freeze),
      .addr_err   (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access: inputs applied just after an edge, optionally changed once
   // after sample number chg_at, dropped just after the ready cycle.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int chg_at,
                         input logic c_rd, input logic c_wr, input logic [31:0] c_addr,
                         input logic [31:0] c_data,
                         output int lat, output int frz, output logic [31:0] rdata,
                         output logic err);
      @(posedge clk); #1;
      MEM_R_EN = rd; MEM_W_EN = wr; ALU_result = addr; Val_Rm = data;
      lat = 0; frz = 0; rdata = '0; err = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (freeze) frz++;
         if (ready) begin
            rdata = read_data;
            err   = addr_err;
            break;
         end
         if (lat == chg_at) begin
            MEM_R_EN = c_rd; MEM_W_EN = c_wr; ALU_result = c_addr; Val_Rm = c_data;
         end
      end
      @(posedge clk); #1;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
   endtask

   task automatic simple(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, output int lat, output int frz,
                         output logic [31:0] rdata, output logic err);
      access(rd, wr, addr, data, -1, 1'b0, 1'b0, 32'd0, 32'd0, lat, frz, rdata, err);
   endtask

   initial begin
      int          lat, frz, c1, c2, nfl;
      logic [31:0] rdata, last_rd;
      logic        err;
      n_vec = 0; n_err = 0;
      rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = '0; Val_Rm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_freeze", {31'd0, freeze}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      check("rst_err", {31'd0, addr_err}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 64; i++) begin
         model[i] = 32'hA000_0000 + 32'(i);
         simple(1'b0, 1'b1, 32'd1024 + 32'(4 * i), model[i], lat, frz, rdata, err);
      end

      simple(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, frz, rdata, err);
      model[0] = 32'hDEADBEEF;
      check("st_lat", 32'(lat), 32'd7);
      check("st_frz", 32'(frz), 32'd6);
      check("st_err", {31'd0, err}, 32'd0);
      simple(1'b1, 1'b0, 32'd1024, 32'd0, lat, frz, rdata, err);
      check("ld_lat", 32'(lat), 32'd7);
      check("ld_frz", 32'(frz), 32'd6);
      check("ld_data", rdata, 32'hDEADBEEF);
      check("ld_err", {31'd0, err}, 32'd0);

      simple(1'b0, 1'b1, 32'd1028, 32'h11, lat, frz, rdata, err);
      model[1] = 32'h11;
      simple(1'b0, 1'b1, 32'd1279, 32'h22, lat, frz, rdata, err);
      model[63] = 32'h22;
      simple(1'b1, 1'b0, 32'd1031, 32'd0, lat, frz, rdata, err);
      check("map_1031", rdata, 32'h11);
      simple(1'b1, 1'b0, 32'd1276, 32'd0, lat, frz, rdata, err);
      check("map_1276", rdata, 32'h22);

      simple(1'b1, 1'b0, 32'd1020, 32'd0, lat, frz, rdata, err);
      check("oor_lo_data", rdata, 32'd0);
      check("oor_lo_err", {31'd0, err}, 32'd1);
      check("oor_lo_lat", 32'(lat), 32'd7);
      simple(1'b1, 1'b0, 32'd1280, 32'd0, lat, frz, rdata, err);
      check("oor_hi_data", rdata, 32'd0);
      check("oor_hi_err", {31'd0, err}, 32'd1);
      check("oor_hi_lat", 32'(lat), 32'd7);

      // Both enables; address and data change mid-busy and must be ignored.
      simple(1'b1, 1'b0, 32'd1028, 32'd0, lat, frz, rdata, err);
      last_rd = rdata;
      check("err_clear", {31'd0, err}, 32'd0);
      access(1'b1, 1'b1, 32'd1040, 32'h5, 2, 1'b1, 1'b1, 32'd1024, 32'h999,
             lat, frz, rdata, err);
      model[4] = 32'h5;
      check("dual_rdata", rdata, last_rd);
      check("dual_lat", 32'(lat), 32'd7);

      simple(1'b0, 1'b1, 32'd1280, 32'h1234, lat, frz, rdata, err);
      check("st_oor_err", {31'd0, err}, 32'd1);
      check("st_oor_rdata", rdata, last_rd);
      for (int i = 0; i < 64; i++) begin
         simple(1'b1, 1'b0, 32'd1024 + 32'(4 * i), 32'd0, lat, frz, rdata, err);
         check($sformatf("sweep_w%0d", i), rdata, model[i]);
      end

      // Flush: request withdrawn after two busy cycles.
      access(1'b0, 1'b1, 32'd1036, 32'hF1F1, 3, 1'b0, 1'b0, 32'd1036, 32'hF1F1,
             lat, frz, rdata, err);
      model[3] = 32'hF1F1;
      check("flush_lat", 32'(lat), 32'd7);
      check("flush_frz", 32'(frz), 32'd3);
      simple(1'b1, 1'b0, 32'd1036, 32'd0, lat, frz, rdata, err);
      check("flush_commit", rdata, 32'hF1F1);

      // Reset mid-busy store; set addr_err first so its clearing is visible.
      simple(1'b0, 1'b1, 32'd1280, 32'd0, lat, frz, rdata, err);
      @(posedge clk); #1;
      MEM_W_EN = 1'b1; ALU_result = 32'd1032; Val_Rm = 32'h77;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; MEM_W_EN = 1'b0;
      @(negedge clk);
      check("mrst_ready", {31'd0, ready}, 32'd0);
      check("mrst_freeze", {31'd0, freeze}, 32'd0);
      check("mrst_rdata", read_data, 32'd0);
      check("mrst_err", {31'd0, addr_err}, 32'd0);
      rst = 1'b0;
      simple(1'b1, 1'b0, 32'd1032, 32'd0, lat, frz, rdata, err);
      check("mrst_word", rdata, model[2]);
      check("mrst_lat", 32'(lat), 32'd7);
      check("mrst_frz", 32'(frz), 32'd6);

      // Back-to-back loads with the request held across DONE.
      @(posedge clk); #1;
      MEM_R_EN = 1'b1; ALU_result = 32'd1024;
      c1 = 0; c2 = 0; nfl = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (!freeze) nfl++;
         if (ready && c1 == 0) c1 = k;
         else if (ready) c2 = k;
      end
      @(posedge clk); #1;
      MEM_R_EN = 1'b0;
      check("b2b_first", 32'(c1), 32'd7);
      check("b2b_gap", 32'(c2 - c1), 32'd7);
      check("b2b_frz_low", 32'(nfl), 32'd2);
      check("b2b_data", read_data, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-stage responder for the load/store requests issued by the execute stage.
- Inputs per request: MEM_R_EN or MEM_W_EN, byte address on ALU_result, store data on Val_Rm.
- Models a slow word-wide data memory with a fixed number of wait states.
- Raises freeze to hold the upstream pipeline until the access completes, then returns load data with a one-cycle ready pulse.

Parameters:
- DEPTH, 64, number of 32-bit words in the internal array.
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 5, busy cycles per access; legal range is 1 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_R_EN  input  1  load request, level; held by the pipeline while freeze is high.
- MEM_W_EN  input  1  store request, level; held while freeze is high.
- ALU_result  input  32  byte address of the access.
- Val_Rm  input  32  store data.
- read_data  output  32  load result; valid while ready=1 for a load.
- ready  output  1  one-cycle pulse marking access completion.
- freeze  output  1  pipeline stall; high while a request is present and ready=0.
- addr_err  output  1  registered flag; set on completion of an out-of-range access.

Behaviour:
- Address mapping:
  - word index = (ALU_result - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
  - Bits [1:0] are ignored.
  - Out of range when ALU_result < BASE_ADDR or index >= DEPTH.
- Request: req = MEM_R_EN | MEM_W_EN. If both are high, the access is a store (write priority).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready=0. At an edge with req=1, latch op, index, range check and Val_Rm; clear the counter; go to BUSY.
  - BUSY: ready=0. The counter increments each edge. At the edge where counter == WAIT_CYCLES-1, perform the access:
    - store: write the array if in range;
    - load: read_data <= array[index], or 0 if out of range;
    - addr_err <= out-of-range.
    - Then go to DONE.
  - DONE: ready=1 for exactly one cycle. The next edge always returns to IDLE, regardless of req. This prevents re-triggering on the still-held request.
- freeze = req & ~ready (combinational).
- Timing: a request first visible in cycle 0 gives freeze high in cycles 0..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1. Total latency is WAIT_CYCLES+2 cycles; the default is 7 cycles with 6 frozen.
- Changes on inputs during BUSY are ignored; the latched values are used.
- If req drops mid-access (flush), the access still completes. The store commits and ready still pulses.
- Back-to-back: a new request present in the cycle after DONE is accepted from IDLE normally. There is no idle gap beyond that cycle.
- read_data holds its last load value until the next load completes. Stores do not change read_data.
- addr_err holds until the next completed access.
- Reset (any state, including mid-BUSY):
  - state=IDLE, counter=0, read_data=0, ready=0, addr_err=0.
  - An in-flight store is aborted and not written.
  - freeze follows req from the first cycle after reset.
- The memory array is not cleared by reset; contents persist.

Test Plan:
- Store then load: MEM_W_EN=1, ALU_result=1024, Val_Rm=0xDEADBEEF held until ready. Then MEM_R_EN=1 at 1024. Required: freeze high 6 cycles each; ready in the 7th; read_data=0xDEADBEEF; addr_err=0.
- Address mapping: store 0x11 at 1028, 0x22 at 1279; load 1031 and 1276. Required: 0x11 and 0x22 (low bits ignored; 1279 maps to word 63).
- Out of range:
  - load at 1020 and at 1280: read_data=0, addr_err=1 with ready, latency unchanged.
  - store at 1280: no array word changes (verify by reading all 64 words).
- Dual enable / input change: both enables at 1040 with data 0x5; Val_Rm and ALU_result changed during BUSY. Required: 0x5 written to word 4 only; read_data unchanged.
- Flush and reset: req dropped after 2 BUSY cycles gives ready after 5 BUSY cycles total and a committed store. Separately, rst pulsed in BUSY during a store of 0x77 to 1032: the word keeps its old value, all outputs are 0 the next cycle, and the following request takes the full 7 cycles.
- Back-to-back loads with req held continuously across DONE: two ready pulses exactly 7 cycles apart; freeze low only in the DONE cycles.
